// File: rtl/axi_r_pkg.sv
// axi_r_pkg: shared types and constants for the slave-side AXI read engine
// Contents: burst_t (FIXED/INCR), resp_t (OKAY/SLVERR/DECERR),
//           r_beat_t packed R-beat {id, data, resp, last}, R_BEAT_W
package axi_r_pkg;
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01
    } burst_t;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;
    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        resp_t       resp;
        logic        last;
    } r_beat_t;
    localparam int R_BEAT_W = 43;
endpackage

// File: rtl/r_skid_reg.sv
// r_skid_reg: one-entry holding register that parks an R beat while the FIFO is full
// Ports: clk, rst (sync, active-high); i_load captures i_data and sets valid;
//        i_unload clears valid; o_valid/o_data expose the parked beat
module r_skid_reg
    import axi_r_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_load,
    input  logic    i_unload,
    input  r_beat_t i_data,
    output logic    o_valid,
    output r_beat_t o_data
);
    logic    r_valid;
    r_beat_t r_data;
    always_ff @(posedge clk) begin
        if (rst)
            r_valid <= 1'b0;
        else if (i_load)
            r_valid <= 1'b1;
        else if (i_unload)
            r_valid <= 1'b0;
    end
    always_ff @(posedge clk) begin
        if (i_load)
            r_data <= i_data;
    end
    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/axi_slave_read_engine.sv
// axi_slave_read_engine: AXI AR/R engine reading a 1-cycle SRAM into the R-channel CDC FIFO
// Ports: clk, rst (sync, active-high)
//        AR channel : i_arvalid, o_arready, i_arid, i_araddr, i_arlen, i_arsize, i_arburst
//        SRAM       : o_mem_cs, o_mem_addr, i_mem_rdata (valid the cycle after o_mem_cs)
//        FIFO write : o_r_wpush, o_r_wdata {rid, rdata, rresp, rlast}, i_r_wfull
module axi_slave_read_engine
    import axi_r_pkg::*;
#(
    parameter int          ID_W    = 8,
    parameter int          DATA_W  = 32,
    parameter int          MEM_AW  = 14,
    parameter logic [15:0] BASE_HI = 16'h0001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_arvalid,
    output logic                o_arready,
    input  logic [ID_W-1:0]     i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [3:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    output logic                o_mem_cs,
    output logic [MEM_AW-1:0]   o_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_r_wpush,
    output logic [R_BEAT_W-1:0] o_r_wdata,
    input  logic                i_r_wfull
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;
    logic [1:0]        r_state;
    logic [ID_W-1:0]   r_id;
    logic [MEM_AW-1:0] r_addr;
    logic [4:0]        r_beats;
    logic [4:0]        r_issued;
    logic [4:0]        r_pushed;
    logic              r_incr;
    logic              r_rd_pend;
    resp_t             r_resp;
    logic              w_ar_hs;
    logic              w_hit;
    logic              w_ok;
    logic              w_issue;
    logic              w_hold_valid;
    logic              w_load;
    logic              w_unload;
    logic              w_push;
    logic              w_last_push;
    logic [4:0]        w_ret_idx;
    logic              w_unused_addr;
    r_beat_t           w_mem_beat;
    r_beat_t           w_err_beat;
    r_beat_t           w_hold_beat;
    r_beat_t           w_beat;
    assign w_unused_addr = ^i_araddr;
    assign o_arready = (r_state == S_IDLE) && !rst;
    assign w_ar_hs   = i_arvalid && o_arready;
    assign w_hit     = i_araddr[31:16] == BASE_HI;
    assign w_ok      = w_hit && (i_arsize == 3'b010) &&
                       (i_arburst == BURST_FIXED || i_arburst == BURST_INCR);
    // Stop issuing when a returning beat has nowhere to go, so hold never needs a second entry
    assign w_issue    = !rst && (r_state == S_BURST) && (r_issued < r_beats) &&
                        !w_hold_valid && !(r_rd_pend && i_r_wfull);
    assign o_mem_cs   = w_issue;
    assign o_mem_addr = r_addr;
    // A parked beat is always older than the one returning now
    assign w_ret_idx  = r_pushed + 5'(w_hold_valid);
    assign w_mem_beat = '{id: r_id, data: i_mem_rdata, resp: RESP_OKAY,
                          last: (w_ret_idx == r_beats - 5'd1)};
    assign w_err_beat = '{id: r_id, data: '0, resp: r_resp,
                          last: (r_pushed == r_beats - 5'd1)};
    assign w_load   = r_rd_pend && (w_hold_valid || i_r_wfull);
    assign w_unload = w_hold_valid && !i_r_wfull;
    assign w_push   = !rst && !i_r_wfull && ((r_state == S_ERR) || w_hold_valid || r_rd_pend);
    assign w_beat   = (r_state == S_ERR) ? w_err_beat : w_hold_valid ? w_hold_beat : w_mem_beat;
    assign w_last_push = w_push && (r_pushed == r_beats - 5'd1);
    assign o_r_wpush = w_push;
    assign o_r_wdata = w_beat;
    r_skid_reg u_hold (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_unload (w_unload),
        .i_data   (w_mem_beat),
        .o_valid  (w_hold_valid),
        .o_data   (w_hold_beat)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_issued  <= '0;
            r_pushed  <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            if (w_ar_hs) begin
                r_state  <= w_ok ? S_BURST : S_ERR;
                r_id     <= i_arid;
                r_addr   <= i_araddr[MEM_AW+1:2];
                r_beats  <= {1'b0, i_arlen} + 5'd1;
                r_incr   <= i_arburst[0];
                r_resp   <= w_hit ? RESP_SLVERR : RESP_DECERR;
                r_issued <= '0;
                r_pushed <= '0;
            end
            if (w_issue) begin
                r_issued <= r_issued + 5'd1;
                if (r_incr)
                    r_addr <= r_addr + MEM_AW'(1);
                if (r_issued + 5'd1 == r_beats)
                    r_state <= S_DRAIN;
            end
            if (w_push)
                r_pushed <= r_pushed + 5'd1;
            if (w_last_push && (r_state == S_DRAIN || r_state == S_ERR))
                r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_axi_slave_read_engine.sv
// tb_axi_slave_read_engine: table-driven bench with a beat/address scoreboard for axi_slave_read_engine
module tb_axi_slave_read_engine;
    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
    } vec_t;
    logic        clk = 0;
    logic        rst = 1;
    logic        i_arvalid = 0;
    logic        o_arready;
    logic [7:0]  i_arid = 0;
    logic [31:0] i_araddr = 0;
    logic [3:0]  i_arlen = 0;
    logic [2:0]  i_arsize = 0;
    logic [1:0]  i_arburst = 0;
    logic        o_mem_cs;
    logic [13:0] o_mem_addr;
    logic [31:0] i_mem_rdata = 0;
    logic        o_r_wpush;
    logic [42:0] o_r_wdata;
    logic        i_r_wfull = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] sram [0:16383];
    logic [42:0] exp_q[$];
    logic [13:0] addr_q[$];
    int          push_cyc[$];
    vec_t        tbl [9];
    axi_slave_read_engine dut (
        .clk         (clk),
        .rst         (rst),
        .i_arvalid   (i_arvalid),
        .o_arready   (o_arready),
        .i_arid      (i_arid),
        .i_araddr    (i_araddr),
        .i_arlen     (i_arlen),
        .i_arsize    (i_arsize),
        .i_arburst   (i_arburst),
        .o_mem_cs    (o_mem_cs),
        .o_mem_addr  (o_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .o_r_wpush   (o_r_wpush),
        .o_r_wdata   (o_r_wdata),
        .i_r_wfull   (i_r_wfull)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (o_mem_cs) i_mem_rdata <= sram[o_mem_addr];
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (rst) begin
            check("rst_quiet", {61'd0, o_arready, o_mem_cs, o_r_wpush}, 64'd0);
        end else begin
            if (o_r_wpush) begin
                push_cyc.push_back(cyc);
                check("push_while_full", {63'd0, i_r_wfull}, 64'd0);
                if (exp_q.size() == 0)
                    check("unexpected_push", {21'd0, o_r_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    check("beat", {21'd0, o_r_wdata}, {21'd0, exp_q.pop_front()});
            end
            if (o_mem_cs) begin
                if (addr_q.size() == 0)
                    check("unexpected_mem_cs", {50'd0, o_mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    check("mem_addr", {50'd0, o_mem_addr}, {50'd0, addr_q.pop_front()});
            end
        end
    end
    task automatic issue_ar(input vec_t v, output int hs);
        int n = 0;
        logic [13:0] w;
        w = v.addr[15:2];
        while (!o_arready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("arready_wait", {63'd0, o_arready}, 64'd1);
        for (int i = 0; i <= int'(v.len); i++) begin
            logic [13:0] a;
            a = (v.burst == 2'b01) ? w + 14'(i) : w;
            exp_q.push_back({v.id, (v.resp == 2'b00) ? sram[a] : 32'h0, v.resp, i == int'(v.len)});
            if (v.resp == 2'b00)
                addr_q.push_back(a);
        end
        push_cyc.delete();
        i_arvalid = 1;
        i_arid = v.id;
        i_araddr = v.addr;
        i_arlen = v.len;
        i_arsize = v.size;
        i_arburst = v.burst;
        @(posedge clk);
        #1;
        hs = cyc;
        i_arvalid = 0;
    endtask
    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_beats_left", 64'(exp_q.size()), 64'd0);
        check("drain_addrs_left", 64'(addr_q.size()), 64'd0);
        exp_q.delete();
        addr_q.delete();
    endtask
    task automatic run_vec(input vec_t v);
        int hs;
        issue_ar(v, hs);
        wait_done();
        @(negedge clk);
        check("arready_after_last", {63'd0, o_arready}, 64'd1);
        if (push_cyc.size() != 0) begin
            check("first_push_cycle", 64'(push_cyc[0]), 64'(hs + ((v.resp == 2'b00) ? 1 : 0)));
            check("last_push_cycle", 64'(push_cyc[$]), 64'(push_cyc[0] + int'(v.len)));
            check("arready_cycle", 64'(cyc), 64'(push_cyc[$] + 1));
        end
        check("push_count", 64'(push_cyc.size()), 64'(int'(v.len) + 1));
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int hs;
        vec_t v;
        for (int i = 0; i < 16384; i++)
            sram[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        tbl[0] = '{id: 8'h5A, addr: 32'h0001_0010, len: 4'd3,  size: 3'b010, burst: 2'b01, resp: 2'b00};
        tbl[1] = '{id: 8'h11, addr: 32'h0001_0024, len: 4'd2,  size: 3'b010, burst: 2'b00, resp: 2'b00};
        tbl[2] = '{id: 8'h22, addr: 32'h0002_0000, len: 4'd1,  size: 3'b010, burst: 2'b01, resp: 2'b11};
        tbl[3] = '{id: 8'h33, addr: 32'h0001_0000, len: 4'd0,  size: 3'b010, burst: 2'b10, resp: 2'b10};
        tbl[4] = '{id: 8'h44, addr: 32'h0001_FFFC, len: 4'd1,  size: 3'b010, burst: 2'b01, resp: 2'b00};
        tbl[5] = '{id: 8'h55, addr: 32'h0001_0100, len: 4'd0,  size: 3'b011, burst: 2'b01, resp: 2'b10};
        tbl[6] = '{id: 8'h66, addr: 32'h0001_0040, len: 4'd15, size: 3'b010, burst: 2'b01, resp: 2'b00};
        tbl[7] = '{id: 8'h77, addr: 32'h0003_0000, len: 4'd2,  size: 3'b010, burst: 2'b10, resp: 2'b11};
        tbl[8] = '{id: 8'h88, addr: 32'h0001_0080, len: 4'd3,  size: 3'b010, burst: 2'b11, resp: 2'b10};
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("reset_arready", {63'd0, o_arready}, 64'd1);
        check("reset_outputs", {62'd0, o_mem_cs, o_r_wpush}, 64'd0);
        for (int i = 0; i < 9; i++)
            run_vec(tbl[i]);
        // FIFO full for three cycles starting at the second beat
        v = '{id: 8'h9C, addr: 32'h0001_0080, len: 4'd3, size: 3'b010, burst: 2'b01, resp: 2'b00};
        issue_ar(v, hs);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_r_wfull = 1;
        repeat (3) @(posedge clk);
        #1;
        i_r_wfull = 0;
        wait_done();
        check("stall_push_count", 64'(push_cyc.size()), 64'd4);
        if (push_cyc.size() == 4)
            check("stall_last_push_cycle", 64'(push_cyc[3]), 64'(hs + 8));
        @(negedge clk);
        check("stall_arready", {63'd0, o_arready}, 64'd1);
        // reset one cycle after the second push; only two beats and three reads expected
        v = '{id: 8'hD1, addr: 32'h0001_00C0, len: 4'd3, size: 3'b010, burst: 2'b01, resp: 2'b00};
        issue_ar(v, hs);
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        while (addr_q.size() > 3) void'(addr_q.pop_back());
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rst_beats_left", 64'(exp_q.size()), 64'd0);
        check("rst_addrs_left", 64'(addr_q.size()), 64'd0);
        check("rst_push_count", 64'(push_cyc.size()), 64'd2);
        check("rst_arready", {63'd0, o_arready}, 64'd1);
        exp_q.delete();
        addr_q.delete();
        run_vec(v);
        run_vec(tbl[0]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_slave_read_engine.md
# axi_slave_read_engine

Slave-side AXI read-channel engine in the slave clock domain. Accepts AR requests, reads a 1-cycle-latency word SRAM, and packs R beats as {rid, rdata, rresp, rlast} (43 bits) into the write port of the slave-to-AXI R-channel CDC FIFO. It is the producer for that FIFO: it drives push/data and obeys its full flag.

## Interface
- ID_W, 8, AR/R ID width
- DATA_W, 32, data width (beat = ID_W+DATA_W+3 = 43)
- MEM_AW, 14, SRAM word-address width
- BASE_HI, 16'h0001, required araddr[31:16] for a decoded hit
- clk  in  1  slave clock
- rst  in  1  reset; one clock, synchronous, active-high
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- arid  in  ID_W  request ID
- araddr  in  32  byte start address
- arlen  in  4  beats−1
- arsize  in  3  must be 3'b010
- arburst  in  2  00 FIXED, 01 INCR, others unsupported
- mem_cs  out  1  SRAM read strobe
- mem_addr  out  MEM_AW  SRAM word address
- mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_cs
- r_wpush  out  1  FIFO push
- r_wdata  out  43  {rid[7:0], rdata[31:0], rresp[1:0], rlast}
- r_wfull  in  1  FIFO full

## Operation
- States: IDLE, BURST, DRAIN, ERR. arready = (state==IDLE) && !rst.
- AR handshake in IDLE latches id, word address araddr[MEM_AW+1:2], beats = arlen+1, and burst. Next state:
  - BURST if araddr[31:16]==BASE_HI, arsize==3'b010, and arburst is 00 or 01.
  - Otherwise ERR, with rresp DECERR (2'b11) on address miss, else SLVERR (2'b10).
- BURST: issue mem_cs when issued<beats && !hold_valid && !(rd_pend && r_wfull).
  - INCR: mem_addr increments by 1 per issue and wraps modulo 2^MEM_AW.
  - FIXED: mem_addr is constant.
  - After the last issue, go to DRAIN.
- Returned data (rd_pend=1), exactly one of:
  - If hold_valid, or if r_wfull: capture into the hold register.
  - Otherwise: push directly.
- Pushes while hold_valid come from the hold register only. Issue is blocked while hold_valid, so a push and a new capture never collide.
- DRAIN: go to IDLE on the cycle the last beat is pushed.
- ERR: push one beat per cycle while !r_wfull, with rdata=0 and no mem_cs. Go to IDLE after the last beat.
- rresp is OKAY (2'b00) for BURST beats. rlast=1 only on beat index arlen.
- r_wpush is never asserted while r_wfull=1. r_wdata is don't-care when r_wpush=0.
- Reset (any cycle, including mid-burst):
  - state←IDLE; issued, pushed, hold_valid, rd_pend←0.
  - In-flight SRAM data is discarded, with no push on the following cycle.
  - arready=0, mem_cs=0, r_wpush=0 while rst=1.

## Timing
- AR accepted at edge e0 → mem_cs high in cycle e0..e1 → push in cycle e1..e2. AR-to-first-push latency is 2 cycles.
- Throughput is 1 beat/cycle while r_wfull=0.
- FIFO full stall: at most one beat is parked in hold. Hold is pushed in the first cycle with r_wfull=0. Issue resumes the cycle after hold empties.
- Last push at edge eL → state IDLE and arready=1 in the following cycle. Back-to-back bursts have a 1-cycle bubble.
- r_wpush and r_wdata are combinational from state, hold, rd_pend, mem_rdata and r_wfull. There is no combinational path from r_wfull to mem_cs beyond the issue term.

## Structure
- Package axi_r_pkg holds:
  - burst_t (FIXED/INCR) and resp_t (OKAY/SLVERR/DECERR).
  - r_beat_t: packed struct {id[7:0], data[31:0], resp[1:0], last}, 43 bits.
  - Constant R_BEAT_W=43.
- Sub-module r_skid_reg: a one-entry holding register with load/unload, holding r_beat_t. Everything else is inline: the FSM, the address and beat counters, and the issue logic.

## Test plan
- INCR hit: araddr=32'h0001_0010, arlen=3, id=8'h5A, SRAM[4..7]=A..D, r_wfull=0 → pushes on the 4 cycles from e0+2, data A,B,C,D, resp 00, rlast only on D, id 5A. arready returns 1 cycle after the last push.
- FIXED: arlen=2 at word 9 → 3 beats, all SRAM[9], mem_addr constant.
- Full stall: INCR arlen=3, r_wfull held high for 3 cycles starting at the 2nd beat → exactly one beat held, no push while full. All 4 beats delivered in order with no loss or duplicate.
- Errors:
  - araddr=32'h0002_0000, arlen=1 → 2 beats DECERR, data 0, no mem_cs, rlast on the 2nd.
  - arburst=2'b10 → SLVERR.
- Reset mid-burst: rst asserted for 1 cycle after the 2nd push of a 4-beat burst → no further pushes. Returns to IDLE. The next AR is served normally from beat 0.
- Wrap: INCR at word 14'h3FFF, arlen=1 → mem_addr 3FFF then 0000.
